// File: rtl/multi_cpu.sv
// Multi-cycle MIPS-subset core with one shared memory/IO bus.
// Latency: 3 cycles (branch/jump), 4 cycles (ALU, sw), 5 cycles (lw).
// Backpressure: IF, MEM_RD and MEM_WR hold all state while MIO_ready is low.
module multi_cpu (
  input  logic        clk,
  input  logic        reset,
  input  logic        MIO_ready,
  input  logic        INT,
  input  logic [31:0] Data_in,
  output logic [4:0]  state,
  output logic [31:0] inst_out,
  output logic [31:0] PC_out,
  output logic [31:0] Addr_out,
  output logic [31:0] Data_out,
  output logic        mem_w,
  output logic        CPU_MIO
);

  typedef enum logic [4:0] {
    S_IF      = 5'd0,
    S_ID      = 5'd1,
    S_EX_R    = 5'd2,
    S_MEM_ADR = 5'd3,
    S_MEM_RD  = 5'd4,
    S_MEM_WR  = 5'd5,
    S_WB_LW   = 5'd6,
    S_WB_R    = 5'd7,
    S_EX_I    = 5'd8,
    S_WB_I    = 5'd9,
    S_BR      = 5'd10,
    S_J       = 5'd11,
    S_JAL     = 5'd12,
    S_JR      = 5'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0a;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_XORI = 6'h0e;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2a;

  state_t      state_q, state_d;
  logic [31:0] pc_q, ir_q, a_q, b_q, aluout_q, mdr_q;
  logic [31:0] rf_q [32];

  // The interrupt request is reserved and intentionally ignored.
  logic unused_int;
  assign unused_int = INT;

  // Instruction fields, all taken from the registered IR.
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext, imm_zext, jump_tgt;
  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign imm_zext = {16'h0000, ir_q[15:0]};
  // PC already holds PC+4 once IF completes, so the region bits come from it.
  assign jump_tgt = {pc_q[31:28], ir_q[25:0], 2'b00};

  logic [31:0] rs_val, rt_val;
  assign rs_val = (rs == 5'd0) ? 32'h0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'h0 : rf_q[rt];

  // Register-register ALU result used in EX_R; also flags which functs are legal.
  logic [31:0] alu_r;
  logic        r_alu_ok;
  always_comb begin
    alu_r    = 32'h0;
    r_alu_ok = 1'b1;
    case (funct)
      F_ADD:   alu_r = a_q + b_q;
      F_SUB:   alu_r = a_q - b_q;
      F_AND:   alu_r = a_q & b_q;
      F_OR:    alu_r = a_q | b_q;
      F_XOR:   alu_r = a_q ^ b_q;
      F_NOR:   alu_r = ~(a_q | b_q);
      F_SLT:   alu_r = ($signed(a_q) < $signed(b_q)) ? 32'h1 : 32'h0;
      F_SLL:   alu_r = b_q << shamt;
      F_SRL:   alu_r = b_q >> shamt;
      default: r_alu_ok = 1'b0;
    endcase
  end

  // Register-immediate ALU result used in EX_I.
  logic [31:0] alu_i;
  always_comb begin
    alu_i = 32'h0;
    case (op)
      OP_ADDI: alu_i = a_q + imm_sext;
      OP_SLTI: alu_i = ($signed(a_q) < $signed(imm_sext)) ? 32'h1 : 32'h0;
      OP_ANDI: alu_i = a_q & imm_zext;
      OP_ORI:  alu_i = a_q | imm_zext;
      OP_XORI: alu_i = a_q ^ imm_zext;
      OP_LUI:  alu_i = {ir_q[15:0], 16'h0000};
      default: alu_i = 32'h0;
    endcase
  end

  logic br_take;
  assign br_take = (op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Next-state decode; unknown opcodes/functs fall straight back to IF.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: if (MIO_ready) state_d = S_ID;
      S_ID: begin
        case (op)
          OP_R: begin
            if (funct == F_JR) state_d = S_JR;
            else if (r_alu_ok) state_d = S_EX_R;
            else               state_d = S_IF;
          end
          OP_LW, OP_SW:                        state_d = S_MEM_ADR;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
          OP_XORI, OP_LUI:                     state_d = S_EX_I;
          OP_BEQ, OP_BNE:                      state_d = S_BR;
          OP_J:                                state_d = S_J;
          OP_JAL:                              state_d = S_JAL;
          default:                             state_d = S_IF;
        endcase
      end
      S_EX_R:    state_d = S_WB_R;
      S_MEM_ADR: state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  if (MIO_ready) state_d = S_WB_LW;
      S_MEM_WR:  if (MIO_ready) state_d = S_IF;
      S_EX_I:    state_d = S_WB_I;
      default:   state_d = S_IF;
    endcase
  end

  // Datapath registers: PC, IR, operand latches, ALU result and memory data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= 32'h0;
      ir_q     <= 32'h0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      aluout_q <= 32'h0;
      mdr_q    <= 32'h0;
    end else begin
      case (state_q)
        S_IF: begin
          if (MIO_ready) begin
            ir_q <= Data_in;
            pc_q <= pc_q + 32'd4;
          end
        end
        S_ID: begin
          a_q      <= rs_val;
          b_q      <= rt_val;
          aluout_q <= pc_q + {imm_sext[29:0], 2'b00};
        end
        S_EX_R:    aluout_q <= alu_r;
        S_MEM_ADR: aluout_q <= a_q + imm_sext;
        S_MEM_RD:  if (MIO_ready) mdr_q <= Data_in;
        S_EX_I:    aluout_q <= alu_i;
        S_BR:      if (br_take) pc_q <= aluout_q;
        S_J:       pc_q <= jump_tgt;
        S_JAL:     pc_q <= jump_tgt;
        S_JR:      pc_q <= a_q;
        default:   ;
      endcase
    end
  end

  // Register-file write port: one source per write-back state.
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'h0;
    case (state_q)
      S_WB_LW: begin rf_we = 1'b1; rf_waddr = rt;    rf_wdata = mdr_q;    end
      S_WB_R:  begin rf_we = 1'b1; rf_waddr = rd;    rf_wdata = aluout_q; end
      S_WB_I:  begin rf_we = 1'b1; rf_waddr = rt;    rf_wdata = aluout_q; end
      S_JAL:   begin rf_we = 1'b1; rf_waddr = 5'd31; rf_wdata = pc_q;     end
      default: ;
    endcase
  end

  // Register file; $0 is never written so it always reads as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Bus outputs decode from registers only, so they are stable across MEM_WR.
  always_comb begin
    state    = state_q;
    inst_out = ir_q;
    PC_out   = pc_q;
    Data_out = b_q;
    Addr_out = (state_q == S_IF) ? pc_q : aluout_q;
    mem_w    = (state_q == S_MEM_WR);
    CPU_MIO  = (state_q == S_IF) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  end

endmodule

// File: tb/tb_multi_cpu.sv
// Bench for multi_cpu: unified memory model, ISA-level reference model, directed and random programs.
module tb_multi_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MIO_ready = 1'b1;
  logic        INT = 1'b0;
  logic [31:0] Data_in;
  logic [4:0]  state;
  logic [31:0] inst_out, PC_out, Addr_out, Data_out;
  logic        mem_w, CPU_MIO;

  multi_cpu dut (
    .clk(clk), .reset(reset), .MIO_ready(MIO_ready), .INT(INT), .Data_in(Data_in),
    .state(state), .inst_out(inst_out), .PC_out(PC_out), .Addr_out(Addr_out),
    .Data_out(Data_out), .mem_w(mem_w), .CPU_MIO(CPU_MIO)
  );

  always #50 clk = ~clk;

  // RAM words 0..4095 at addr[13:2]; IO window 0xFxxxxxxx maps to 16 extra words.
  logic [31:0] dmem [0:4111];
  logic [31:0] mmem [0:4111];

  function automatic int midx(input logic [31:0] a);
    if (a[31:28] == 4'hF) return 4096 + int'(a[5:2]);
    return int'(a[13:2]);
  endfunction

  assign Data_in = dmem[midx(Addr_out)];

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [31:0] pc;   logic [31:0] cyc;  } tr_t;

  wr_t         wlog[$];
  wr_t         exp_wr[$];
  tr_t         trace[$];
  logic [31:0] exp_pc[$];
  int          exp_cyc[$];
  logic [31:0] rdaddr[$];
  logic [31:0] prog[$];

  int       n_checks = 0;
  int       n_errors = 0;
  int       rdy_mode = 1;   // 0: hold low, 1: always ready, 2: random
  int       cyc_cnt = 0;
  logic [4:0] prev_st = 5'h1f;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tr_pc(input int i);
    if (i < trace.size()) return trace[i].pc;
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] wl_dat(input int i);
    if (i < wlog.size()) return wlog[i].data;
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic next_rdy();
    if (rdy_mode == 0) return 1'b0;
    if (rdy_mode == 1) return 1'b1;
    return ($urandom_range(0, 2) != 0);
  endfunction

  // Observe the bus at the falling edge: instruction starts, read addresses, committed stores.
  task automatic sample();
    if (!reset) begin
      cyc_cnt++;
      if (state == 5'd0 && prev_st != 5'd0) begin
        trace.push_back({PC_out, 32'(cyc_cnt)});
        cyc_cnt = 0;
      end
      prev_st = state;
      if (state == 5'd4) rdaddr.push_back(Addr_out);
      if (mem_w && MIO_ready) begin
        dmem[midx(Addr_out)] = Data_out;
        wlog.push_back({Addr_out, Data_out});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #5 MIO_ready = next_rdy();
    @(negedge clk);
    sample();
  endtask

  // Reference model: executes the program instruction by instruction on plain arrays.
  task automatic model_run(input logic [31:0] halt_pc);
    logic [31:0] r [32];
    logic [31:0] pc, npc, ir, se, ze, ea;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    int          cyc;
    for (int i = 0; i < 32; i++) r[i] = 32'h0;
    pc = 32'h0;
    exp_pc.delete(); exp_cyc.delete(); exp_wr.delete();
    for (int k = 0; k < 2000 && pc != halt_pc; k++) begin
      ir = mmem[midx(pc)];
      op = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
      sh = ir[10:6];  fn = ir[5:0];
      se = {{16{ir[15]}}, ir[15:0]};
      ze = {16'h0, ir[15:0]};
      npc = pc + 32'd4;
      cyc = 4;
      exp_pc.push_back(pc);
      case (op)
        6'h00: begin
          case (fn)
            6'h20: if (rd != 0) r[rd] = r[rs] + r[rt];
            6'h22: if (rd != 0) r[rd] = r[rs] - r[rt];
            6'h24: if (rd != 0) r[rd] = r[rs] & r[rt];
            6'h25: if (rd != 0) r[rd] = r[rs] | r[rt];
            6'h26: if (rd != 0) r[rd] = r[rs] ^ r[rt];
            6'h27: if (rd != 0) r[rd] = ~(r[rs] | r[rt]);
            6'h2a: if (rd != 0) r[rd] = ($signed(r[rs]) < $signed(r[rt])) ? 32'd1 : 32'd0;
            6'h00: if (rd != 0) r[rd] = r[rt] << sh;
            6'h02: if (rd != 0) r[rd] = r[rt] >> sh;
            6'h08: begin npc = r[rs]; cyc = 3; end
            default: cyc = 2;
          endcase
        end
        6'h08: if (rt != 0) r[rt] = r[rs] + se;
        6'h0a: if (rt != 0) r[rt] = ($signed(r[rs]) < $signed(se)) ? 32'd1 : 32'd0;
        6'h0c: if (rt != 0) r[rt] = r[rs] & ze;
        6'h0d: if (rt != 0) r[rt] = r[rs] | ze;
        6'h0e: if (rt != 0) r[rt] = r[rs] ^ ze;
        6'h0f: if (rt != 0) r[rt] = {ir[15:0], 16'h0};
        6'h23: begin ea = r[rs] + se; if (rt != 0) r[rt] = mmem[midx(ea)]; cyc = 5; end
        6'h2b: begin ea = r[rs] + se; mmem[midx(ea)] = r[rt]; exp_wr.push_back({ea, r[rt]}); end
        6'h04: begin if (r[rs] == r[rt]) npc = npc + (se << 2); cyc = 3; end
        6'h05: begin if (r[rs] != r[rt]) npc = npc + (se << 2); cyc = 3; end
        6'h02: begin npc = {npc[31:28], ir[25:0], 2'b00}; cyc = 3; end
        6'h03: begin r[31] = npc; npc = {npc[31:28], ir[25:0], 2'b00}; cyc = 3; end
        default: cyc = 2;
      endcase
      exp_cyc.push_back(cyc);
      pc = npc;
    end
    exp_pc.push_back(pc);
  endtask

  // Assert reset, clear the bus memory and load prog at address 0.
  task automatic begin_test();
    reset = 1'b1;
    for (int i = 0; i < 4112; i++) dmem[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) dmem[i] = prog[i];
    trace.delete(); wlog.delete(); rdaddr.delete();
    prev_st = 5'h1f;
    cyc_cnt = 0;
    tick();
    tick();
  endtask

  // Snapshot memory for the model, then release reset mid-high so the first IF is sampled.
  task automatic release_reset();
    mmem = dmem;
    model_run(32'(4 * (prog.size() - 1)));
    @(posedge clk);
    MIO_ready = next_rdy();
    #10 reset = 1'b0;
    @(negedge clk);
    sample();
  endtask

  task automatic run_check(input bit chk_cyc);
    int n, budget;
    n = exp_pc.size();
    budget = 0;
    while (trace.size() < n && budget < 60 * n + 50) begin
      tick();
      budget++;
    end
    check32("run_complete", 32'(trace.size() >= n), 32'd1);
    for (int i = 0; i < n && i < trace.size(); i++) begin
      check32($sformatf("pc[%0d]", i), trace[i].pc, exp_pc[i]);
      if (chk_cyc && i + 1 < n && i + 1 < trace.size())
        check32($sformatf("cycles[%0d]", i), trace[i + 1].cyc, 32'(exp_cyc[i]));
    end
    check32("write_count", 32'(wlog.size()), 32'(exp_wr.size()));
    for (int i = 0; i < wlog.size() && i < exp_wr.size(); i++) begin
      check32($sformatf("wr_addr[%0d]", i), wlog[i].addr, exp_wr[i].addr);
      check32($sformatf("wr_data[%0d]", i), wlog[i].data, exp_wr[i].data);
    end
  endtask

  task automatic gen_random(input int len);
    logic [5:0]  rfn [9];
    logic [5:0]  iop [6];
    int          kind, off;
    logic [4:0]  rs, rt, rd;
    rfn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h00, 6'h02};
    iop = '{6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
    prog.delete();
    for (int i = 0; i < len; i++) begin
      kind = $urandom_range(0, 9);
      rs = 5'($urandom_range(0, 15));
      rt = 5'($urandom_range(0, 15));
      rd = 5'($urandom_range(0, 15));
      off = $urandom_range(0, 3);
      case (kind)
        0, 1, 2: prog.push_back({6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), rfn[$urandom_range(0, 8)]});
        3, 4, 9: prog.push_back({iop[$urandom_range(0, 5)], rs, rt, 16'($urandom)});
        5: prog.push_back({6'h23, 5'd0, rt, 16'(32'h2000 + 4 * off)});
        6: prog.push_back({6'h2b, 5'd0, rt, 16'(32'h2000 + 4 * off)});
        7: prog.push_back({($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05,
                           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'(off)});
        default: prog.push_back({($urandom_range(0, 1) != 0) ? 6'h02 : 6'h03, 26'(i + 1 + off)});
      endcase
    end
    for (int r = 1; r < 32; r++) prog.push_back({6'h2b, 5'd0, 5'(r), 16'(32'h3000 + 4 * r)});
    prog.push_back(32'h1000_ffff);
  endtask

  logic [31:0] exp_regs [6];
  logic [31:0] br_pcs [14];

  initial begin
    // lui: reset values, state sequence, then a three-cycle IF stall.
    rdy_mode = 1;
    prog = '{32'h3c03f000, 32'hac030000, 32'h1000ffff};
    begin_test();
    release_reset();
    check32("rst_state", 32'(state), 32'd0);
    check32("rst_pc", PC_out, 32'h0);
    check32("rst_ir", inst_out, 32'h0);
    check32("rst_addr", Addr_out, 32'h0);
    check32("rst_mio", 32'(CPU_MIO), 32'd1);
    check32("rst_memw", 32'(mem_w), 32'd0);
    check32("rst_dout", Data_out, 32'h0);
    tick();
    check32("lui_st1", 32'(state), 32'd1);
    check32("lui_pc4", PC_out, 32'h4);
    check32("lui_ir", inst_out, 32'h3c03f000);
    tick();
    check32("lui_st2", 32'(state), 32'd8);
    rdy_mode = 0;
    tick();
    check32("lui_st3", 32'(state), 32'd9);
    tick();
    check32("lui_st4", 32'(state), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check32($sformatf("stall_state[%0d]", k), 32'(state), 32'd0);
      check32($sformatf("stall_pc[%0d]", k), PC_out, 32'h4);
    end
    rdy_mode = 1;
    run_check(1'b0);
    check32("lui_store", wl_dat(0), 32'hF000_0000);

    // ALU program, then store each result to address 0.
    prog = '{32'h3c03f000, 32'h2014003f, 32'h3c088000, 32'h00632020, 32'h20020001, 32'h00000827,
             32'hac030000, 32'hac140000, 32'hac080000, 32'hac040000, 32'hac020000, 32'hac010000,
             32'h1000ffff};
    exp_regs = '{32'hF000_0000, 32'h0000_003F, 32'h8000_0000, 32'hE000_0000, 32'h1, 32'hFFFF_FFFF};
    begin_test();
    release_reset();
    run_check(1'b1);
    for (int i = 0; i < 6; i++) check32($sformatf("alu_reg[%0d]", i), wl_dat(i), exp_regs[i]);

    // Store to the IO window and load it back.
    prog = '{32'h3c09f000, 32'h2014003f, 32'had340000, 32'h8d2a0000, 32'hac0a0000, 32'h1000ffff};
    begin_test();
    release_reset();
    run_check(1'b1);
    check32("io_wr_addr", (wlog.size() > 0) ? wlog[0].addr : 32'hDEAD_BEEF, 32'hF000_0000);
    check32("io_rd_addr", (rdaddr.size() > 0) ? rdaddr[0] : 32'hDEAD_BEEF, 32'hF000_0000);
    check32("lw_value", wl_dat(1), 32'h3F);
    check32("lw_cycles", (trace.size() > 4) ? trace[4].cyc : 32'hDEAD_BEEF, 32'd5);

    // Branches, jal and jr.
    prog = '{32'h20050007, 32'h20060007, 32'h10a60001, 32'h20070001, 32'h14a60005, 32'h14a00001,
             32'h20070002, 32'h10a00005, 32'h0c00000c, 32'h08000010, 32'h0, 32'h0,
             32'h23e80000, 32'h03e00008, 32'h0, 32'h0, 32'hac1f0000, 32'hac080000,
             32'hac070000, 32'h1000ffff};
    br_pcs = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14, 32'h1C, 32'h20,
               32'h30, 32'h34, 32'h24, 32'h40, 32'h44, 32'h48, 32'h4C};
    begin_test();
    release_reset();
    run_check(1'b1);
    for (int i = 0; i < 14; i++) check32($sformatf("br_pc[%0d]", i), tr_pc(i), br_pcs[i]);
    check32("jal_link", wl_dat(0), 32'h24);
    check32("skipped_reg", wl_dat(2), 32'h0);

    // Reset asserted inside MEM_WR, before the bus would sample the write.
    prog = '{32'h20050055, 32'hac050010, 32'h1000ffff};
    begin_test();
    release_reset();
    for (int k = 0; k < 20 && state != 5'd3; k++) tick();
    check32("rst_wr_pre", 32'(state), 32'd3);
    @(posedge clk);
    #10;
    check32("memwr_state", 32'(state), 32'd5);
    check32("memwr_strobe", 32'(mem_w), 32'd1);
    check32("memwr_addr", Addr_out, 32'h10);
    check32("memwr_data", Data_out, 32'h55);
    reset = 1'b1;
    #1;
    check32("abort_memw", 32'(mem_w), 32'd0);
    check32("abort_state", 32'(state), 32'd0);
    check32("abort_pc", PC_out, 32'h0);
    tick();
    tick();
    check32("abort_nowrite", 32'(wlog.size()), 32'd0);
    check32("abort_mem", dmem[4], 32'h0);

    // Random programs: first with a ready bus (cycle counts checked), then with random stalls.
    for (int s = 0; s < 4; s++) begin
      rdy_mode = (s < 2) ? 1 : 2;
      gen_random(40);
      begin_test();
      for (int k = 0; k < 4; k++) dmem[2048 + k] = $urandom;
      release_reset();
      run_check(s < 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_cpu.md
# multi_cpu

Multi-cycle 32-bit MIPS-subset processor core with a single unified memory/IO bus. It fetches, decodes and executes one instruction over 3–5 clock cycles using a 5-bit state machine. It sits between the SoC memory/peripheral bus (address-decoded RAM, seven-segment and LED registers) and the board clock/reset. The state, IR and PC are exported for debug display.

## Interface
- No parameters.
- `clk` input 1: single system clock; all state changes on rising edge.
- `reset` input 1: asynchronous, active-high; clears PC, IR, state, registers.
- `MIO_ready` input 1: bus ready; memory-access states hold while 0.
- `INT` input 1: reserved interrupt request; has no effect.
- `Data_in` input 32: read data from the bus; combinational with respect to `Addr_out`.
- `state` output 5: current FSM state code.
- `inst_out` output 32: instruction register (IR).
- `PC_out` output 32: program counter.
- `Addr_out` output 32: bus byte address.
- `Data_out` output 32: store data, equal to the rt register value latched in ID.
- `mem_w` output 1: bus write strobe.
- `CPU_MIO` output 1: bus access request.

## Operation
- Instruction set:
  - R-type: add, sub, and, or, xor, nor, slt, sll, srl, jr.
  - I-type: addi, andi, ori, xori, slti, lui, lw, sw, beq, bne.
  - J-type: j, jal.
  - Any other opcode or funct is executed as a no-op; the FSM returns to IF.
- Overflow is ignored; there are no traps.
- Register file: 32×32. Reading $0 always returns 0, and writes to $0 are dropped.
- Immediates:
  - Sign-extended for addi, slti, lw, sw, beq, bne.
  - Zero-extended for andi, ori, xori.
  - lui writes `imm<<16`.
- slt and slti use a signed compare. Shifts use the shamt field on rt.
- States (codes):
  - IF = 0: `Addr_out` = PC, `CPU_MIO` = 1. On the edge: IR ← `Data_in`, PC ← PC+4.
  - ID = 1: A ← rs, B ← rt. ALUOut ← PC + (sext(imm)<<2). Next state is chosen by opcode.
  - EX_R = 2: ALUOut ← A op B (shift: B shifted by shamt) → WB_R.
  - MEM_ADR = 3: ALUOut ← A + sext(imm). lw → MEM_RD, sw → MEM_WR.
  - MEM_RD = 4: `Addr_out` = ALUOut, `CPU_MIO` = 1. MDR ← `Data_in` → WB_LW.
  - MEM_WR = 5: `Addr_out` = ALUOut, `CPU_MIO` = 1, `mem_w` = 1 → IF.
  - WB_LW = 6: rt ← MDR → IF.
  - WB_R = 7: rd ← ALUOut → IF.
  - EX_I = 8: ALUOut ← A op imm (lui: imm<<16) → WB_I.
  - WB_I = 9: rt ← ALUOut → IF.
  - BR = 10: if (A==B) for beq, or (A!=B) for bne, PC ← ALUOut → IF.
  - J = 11: PC ← {PC[31:28], target, 2'b00} → IF.
  - JAL = 12: $31 ← PC; PC ← jump target → IF.
  - JR = 13: PC ← A → IF.
- ID routing:
  - R-type jr → JR; other R-type → EX_R.
  - lw/sw → MEM_ADR.
  - Immediate ALU ops and lui → EX_I.
  - beq/bne → BR.
  - j → J; jal → JAL.
- `Addr_out` outside IF, MEM_RD and MEM_WR equals ALUOut. `CPU_MIO` and `mem_w` are 0 in those states.

## Timing
- Cycle counts:
  - R-type and I-type ALU ops: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branches, j, jal, jr: 3 cycles.
- IF, MEM_RD and MEM_WR stall while `MIO_ready` = 0: the state is held and no register updates. They advance on the first rising edge with `MIO_ready` = 1.
- The bus samples a write on the falling edge inside MEM_WR. `Addr_out`, `Data_out` and `mem_w` are stable for the whole MEM_WR cycle and are decoded from registers only.
- Reset values:
  - PC = 0, IR = 0, state = IF (0).
  - All GPRs, A, B, ALUOut and MDR = 0.
  - Outputs after reset: `Addr_out` = 0, `CPU_MIO` = 1, `mem_w` = 0, `Data_out` = 0.
- Reset asserted mid-instruction aborts it immediately. No partial write occurs after reset assertion.
- Branch offset is relative to PC+4. PC wraps modulo 2^32.

## Test plan
- Reset held for 100 ns, then released, with a 100 ns clock period. Required: `state` sequence 0,1,8,9 for `3c03f000` (lui $3,0xF000). `PC_out` = 4 after the first IF.
- Run program `3c03f000, 2014003f, 3c088000, 00632020, 20020001, 00000827`, followed by `sw` of each register to address 0. Required `Data_out` values with `mem_w` = 1:
  - $3 = F0000000
  - $20 = 0000003F
  - $8 = 80000000
  - $4 = E0000000 (no overflow trap)
  - $2 = 00000001
  - $1 = FFFFFFFF
- sw $20 to `F0000000`, then lw it back. Required: `Addr_out` = F0000000 in states 5 and 4, and the loaded value = 3F. lw takes 5 cycles.
- beq taken and not taken, bne, j, jal, jr. Required: correct `PC_out` targets. jal writes $31 = address of jal + 4.
- `MIO_ready` held 0 for 3 cycles during IF. Required: `state` stays 0 and `PC_out` is unchanged. The FSM proceeds after `MIO_ready` returns to 1.
- Reset asserted during MEM_WR. Required: `mem_w` drops to 0 asynchronously, and `state` = 0, `PC_out` = 0.
